// File: rtl/cbrt_dispatch_pkg.sv
// Shared constants and FSM encoding for the cube-root dispatcher.
package cbrt_dispatch_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int W_DEFAULT     = 8;
  localparam int ACK_TIMEOUT   = 4;
  localparam int ACK_CNT_W     = $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

endpackage

// File: rtl/cbrt_dispatch_sync_fifo.sv
// Operand FIFO: power-of-two depth, order preserving, push accepted at full
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cbrt_dispatch.sv
// Dispatches queued operands one at a time to an external cube-root unit and
// holds each result until the downstream accepts it.
module cbrt_dispatch
  import cbrt_dispatch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = W_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_bi,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_bo,
  output logic         root_start_o,
  output logic [W-1:0] root_x_bo,
  input  logic         root_busy_i,
  input  logic [W-1:0] root_y_bi,
  output logic         err_o
);

  state_e               state_q, state_d;
  logic [ACK_CNT_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [W-1:0]         root_x_q, root_x_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q, err_d;
  logic                 fifo_pop, fifo_full, fifo_empty, root_start;
  logic [W-1:0]         fifo_head;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign in_ready_o   = rst_i & (~fifo_full | fifo_pop);
  assign out_valid_o  = out_valid_q;
  assign out_data_bo  = out_data_q;
  assign root_start_o = root_start;
  assign root_x_bo    = root_x_q;
  assign err_o        = err_q;

  sync_fifo #(
    .DEPTH(DEPTH),
    .W    (W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (in_valid_i & in_ready_o),
    .push_data_i(in_data_bi),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  always_comb begin
    state_d     = state_q;
    ack_cnt_d   = ack_cnt_q;
    root_x_d    = root_x_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    fifo_pop    = 1'b0;
    root_start  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !out_valid_q) begin
          fifo_pop = 1'b1;
          root_x_d = fifo_head;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        root_start = 1'b1;
        ack_cnt_d  = '0;
        state_d    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (root_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!root_busy_i) begin
          out_data_d  = root_y_bi;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      ack_cnt_q   <= '0;
      root_x_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_cnt_q   <= ack_cnt_d;
      root_x_q    <= root_x_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

endmodule
